rdma_rc_pdu_hdr_parser: RTL and testbench



---
 rtl/rdma_rc_pkg.sv | 21 ++
 rtl/rdma_rc_pdu_hdr_parser_if.sv | 31 +++
 rtl/rdma_rc_opcode_classify.sv | 28 ++
 rtl/rdma_rc_pdu_hdr_parser.sv | 81 ++++++++
 tb/tb_rdma_rc_pdu_hdr_parser.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/rdma_rc_pkg.sv
// Shared constants for the RDMA RC header parser: QP state encodings,
// opcode class bounds and default header field offsets.
package rdma_rc_pkg;

    typedef enum logic [2:0] {
        QpReset = 3'b000,
        QpInit  = 3'b001,
        QpRtr   = 3'b010,
        QpRts   = 3'b011,
        QpError = 3'b111
    } qp_state_e;

    localparam logic [7:0] DATA_MAX = 8'h1F;
    localparam logic [7:0] CTRL_MIN = 8'h20;
    localparam logic [7:0] CTRL_MAX = 8'h7F;

    localparam int unsigned DEF_OPCODE_OFFSET = 56;
    localparam int unsigned DEF_QPN_OFFSET    = 32;
    localparam int unsigned DEF_PSN_OFFSET    = 8;

endpackage

// File: rtl/rdma_rc_pdu_hdr_parser_if.sv
// PDU beat in, parsed header results out. The receive side drives the beat
// (master); the parser consumes it and returns the registered results (slave).
interface rdma_rc_pdu_hdr_parser_if #(
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned OPCODE_WIDTH = 8,
    parameter int unsigned QPN_WIDTH    = 16,
    parameter int unsigned PSN_WIDTH    = 24
);
    logic [DATA_WIDTH-1:0]   pdu_data;
    logic                    pdu_valid;
    logic [OPCODE_WIDTH-1:0] pdu_opcode;
    logic [QPN_WIDTH-1:0]    pdu_qpn;
    logic [PSN_WIDTH-1:0]    pdu_psn;
    logic                    is_data_frame;
    logic                    is_control_frame;
    logic                    opcode_err;
    logic                    qpn_mismatch_err;
    logic                    pdu_parse_done;

    modport master (
        output pdu_data, pdu_valid,
        input  pdu_opcode, pdu_qpn, pdu_psn, is_data_frame, is_control_frame,
               opcode_err, qpn_mismatch_err, pdu_parse_done
    );

    modport slave (
        input  pdu_data, pdu_valid,
        output pdu_opcode, pdu_qpn, pdu_psn, is_data_frame, is_control_frame,
               opcode_err, qpn_mismatch_err, pdu_parse_done
    );
endinterface

// File: rtl/rdma_rc_opcode_classify.sv
// Combinational opcode classifier: data/control class flags and legality of
// the opcode's class in the current QP state.
module rdma_rc_opcode_classify
    import rdma_rc_pkg::*;
#(
    parameter int unsigned OPCODE_WIDTH = 8
) (
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [2:0]              qp_state,
    output logic                    is_data,
    output logic                    is_ctrl,
    output logic                    opcode_err
);
    logic legal;

    always_comb begin
        is_data = (32'(opcode) <= 32'(DATA_MAX));
        is_ctrl = (32'(opcode) >= 32'(CTRL_MIN)) && (32'(opcode) <= 32'(CTRL_MAX));
        legal   = 1'b0;
        // Reserved opcodes set neither flag, so they are never legal.
        case (qp_state)
            QpRtr:   legal = is_ctrl;
            QpRts:   legal = is_data;
            default: legal = 1'b0;
        endcase
        opcode_err = !legal;
    end
endmodule

// File: rtl/rdma_rc_pdu_hdr_parser.sv
// Single-beat RDMA RC header parser: slices opcode/QPN/PSN, classifies the
// opcode, checks QPN, and registers all results for one-cycle latency.
module rdma_rc_pdu_hdr_parser
    import rdma_rc_pkg::*;
#(
    parameter int unsigned QPN_WIDTH     = 16,
    parameter int unsigned PSN_WIDTH     = 24,
    parameter int unsigned OPCODE_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned OPCODE_OFFSET = DEF_OPCODE_OFFSET,
    parameter int unsigned QPN_OFFSET    = DEF_QPN_OFFSET,
    parameter int unsigned PSN_OFFSET    = DEF_PSN_OFFSET
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           qp_state,
    input  logic [QPN_WIDTH-1:0] local_qpn,
    input  logic [QPN_WIDTH-1:0] remote_qpn,
    rdma_rc_pdu_hdr_parser_if.slave pdu
);
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [QPN_WIDTH-1:0]    qpn;
    logic [PSN_WIDTH-1:0]    psn;
    logic                    is_data, is_ctrl, op_err, qpn_err;
    logic                    unused_bits;

    assign opcode      = pdu.pdu_data[OPCODE_OFFSET +: OPCODE_WIDTH];
    assign qpn         = pdu.pdu_data[QPN_OFFSET +: QPN_WIDTH];
    assign psn         = pdu.pdu_data[PSN_OFFSET +: PSN_WIDTH];
    assign qpn_err     = (qpn != local_qpn) && (qpn != remote_qpn);
    // Header bits outside the three fields carry nothing for this block.
    assign unused_bits = ^pdu.pdu_data;

    rdma_rc_opcode_classify #(
        .OPCODE_WIDTH (OPCODE_WIDTH)
    ) u_classify (
        .opcode     (opcode),
        .qp_state   (qp_state),
        .is_data    (is_data),
        .is_ctrl    (is_ctrl),
        .opcode_err (op_err)
    );

    logic [OPCODE_WIDTH-1:0] opcode_q;
    logic [QPN_WIDTH-1:0]    qpn_q;
    logic [PSN_WIDTH-1:0]    psn_q;
    logic                    is_data_q, is_ctrl_q, op_err_q, qpn_err_q, done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q  <= '0;
            qpn_q     <= '0;
            psn_q     <= '0;
            is_data_q <= 1'b0;
            is_ctrl_q <= 1'b0;
            op_err_q  <= 1'b0;
            qpn_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= pdu.pdu_valid;
            if (pdu.pdu_valid) begin
                opcode_q  <= opcode;
                qpn_q     <= qpn;
                psn_q     <= psn;
                is_data_q <= is_data;
                is_ctrl_q <= is_ctrl;
                op_err_q  <= op_err;
                qpn_err_q <= qpn_err;
            end
        end
    end

    assign pdu.pdu_opcode       = opcode_q;
    assign pdu.pdu_qpn          = qpn_q;
    assign pdu.pdu_psn          = psn_q;
    assign pdu.is_data_frame    = is_data_q;
    assign pdu.is_control_frame = is_ctrl_q;
    assign pdu.opcode_err       = op_err_q;
    assign pdu.qpn_mismatch_err = qpn_err_q;
    assign pdu.pdu_parse_done   = done_q;
endmodule

// File: tb/tb_rdma_rc_pdu_hdr_parser.sv
// Scoreboard bench for the RDMA RC header parser: each driven beat pushes its
// expected parse result, and every parse_done pulse pops and compares one.
module tb_rdma_rc_pdu_hdr_parser;

    typedef struct packed {
        logic [7:0]  op;
        logic [15:0] qpn;
        logic [23:0] psn;
        logic        data;
        logic        ctrl;
        logic        oerr;
        logic        qerr;
    } exp_t;

    localparam logic [15:0] LocalQpn  = 16'h1234;
    localparam logic [15:0] RemoteQpn = 16'h5678;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  qp_state = 3'b000;
    logic [15:0] local_qpn = LocalQpn;
    logic [15:0] remote_qpn = RemoteQpn;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_sent = 0;
    int   n_seen = 0;
    exp_t sb_q[$];
    exp_t last_exp;

    rdma_rc_pdu_hdr_parser_if #(
        .DATA_WIDTH   (64),
        .OPCODE_WIDTH (8),
        .QPN_WIDTH    (16),
        .PSN_WIDTH    (24)
    ) pdu_if ();

    rdma_rc_pdu_hdr_parser dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .qp_state   (qp_state),
        .local_qpn  (local_qpn),
        .remote_qpn (remote_qpn),
        .pdu        (pdu_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] st, input logic [7:0] op,
                                   input logic [15:0] qpn, input logic [23:0] psn);
        exp_t e;
        e.op   = op;
        e.qpn  = qpn;
        e.psn  = psn;
        e.data = (op < 8'h20);
        e.ctrl = (op >= 8'h20) && (op < 8'h80);
        e.oerr = !((st == 3'b010 && e.ctrl) || (st == 3'b011 && e.data));
        e.qerr = (qpn != LocalQpn) && (qpn != RemoteQpn);
        return e;
    endfunction

    task automatic cmp_fields(input string tag, input exp_t e);
        check({tag, ".opcode"}, 64'(pdu_if.pdu_opcode), 64'(e.op));
        check({tag, ".qpn"}, 64'(pdu_if.pdu_qpn), 64'(e.qpn));
        check({tag, ".psn"}, 64'(pdu_if.pdu_psn), 64'(e.psn));
        check({tag, ".data"}, 64'(pdu_if.is_data_frame), 64'(e.data));
        check({tag, ".ctrl"}, 64'(pdu_if.is_control_frame), 64'(e.ctrl));
        check({tag, ".oerr"}, 64'(pdu_if.opcode_err), 64'(e.oerr));
        check({tag, ".qerr"}, 64'(pdu_if.qpn_mismatch_err), 64'(e.qerr));
    endtask

    task automatic check_zero(input string tag);
        cmp_fields(tag, '0);
        check({tag, ".done"}, 64'(pdu_if.pdu_parse_done), 64'd0);
    endtask

    // Drive one beat at the falling edge, with random filler in unused bits.
    task automatic send(input logic [2:0] st, input logic [7:0] op,
                        input logic [15:0] qpn, input logic [23:0] psn);
        logic [7:0] junk_hi, junk_lo;
        junk_hi = 8'($urandom);
        junk_lo = 8'($urandom);
        @(negedge clk);
        qp_state          = st;
        pdu_if.pdu_data   = {op, junk_hi, qpn, psn, junk_lo};
        pdu_if.pdu_valid  = 1'b1;
        last_exp          = model(st, op, qpn, psn);
        sb_q.push_back(last_exp);
        n_sent++;
    endtask

    // Drop valid, then one cycle later confirm the results are still held.
    task automatic idle_hold(input string tag);
        @(negedge clk);
        pdu_if.pdu_valid = 1'b0;
        pdu_if.pdu_data  = 64'($urandom) << 32 | 64'($urandom);
        qp_state         = 3'($urandom);
        @(negedge clk);
        cmp_fields({tag, ".hold"}, last_exp);
        check({tag, ".hold.done"}, 64'(pdu_if.pdu_parse_done), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && pdu_if.pdu_parse_done) begin
            n_seen++;
            if (sb_q.size() == 0) begin
                check("sb.unexpected_done", 64'd1, 64'd0);
            end else begin
                cmp_fields("sb", sb_q.pop_front());
            end
        end
    end

    initial begin
        logic [2:0]  st_tbl [6];
        logic [15:0] qpn_sel;
        pdu_if.pdu_valid = 1'b0;
        pdu_if.pdu_data  = '0;
        st_tbl = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b111};

        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        send(3'b000, 8'h05, 16'h1234, 24'h000001);
        idle_hold("reset_state");
        send(3'b001, 8'h25, 16'h1234, 24'h000002);
        idle_hold("init_state");
        send(3'b010, 8'h25, 16'h5678, 24'h000003);
        idle_hold("rtr_ctrl");
        send(3'b010, 8'h05, 16'h5678, 24'h000004);
        idle_hold("rtr_data");
        send(3'b011, 8'h05, 16'h1234, 24'h000005);
        idle_hold("rts_data");
        send(3'b011, 8'h25, 16'h1234, 24'h000006);
        idle_hold("rts_ctrl");
        send(3'b011, 8'h85, 16'h1234, 24'h000007);
        idle_hold("rts_reserved");
        send(3'b011, 8'h05, 16'h9999, 24'h000008);
        idle_hold("qpn_mismatch");
        send(3'b011, 8'h1F, 16'h5678, 24'hABCDEF);
        idle_hold("data_max");
        send(3'b010, 8'h7F, 16'h1234, 24'hFFFFFF);
        idle_hold("ctrl_max");
        send(3'b010, 8'h80, 16'h0000, 24'h123456);
        idle_hold("reserved_min");
        send(3'b111, 8'h20, 16'hFFFF, 24'h654321);
        idle_hold("error_state");

        // Asynchronous reset between edges, then a beat presented under reset.
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        @(negedge clk);
        qp_state         = 3'b011;
        pdu_if.pdu_data  = 64'h0500_1234_0000_0900;
        pdu_if.pdu_valid = 1'b1;
        @(negedge clk);
        check_zero("pdu_in_reset");
        pdu_if.pdu_valid = 1'b0;
        rst_n            = 1'b1;
        last_exp         = '0;

        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 2))
                0:       qpn_sel = LocalQpn;
                1:       qpn_sel = RemoteQpn;
                default: qpn_sel = 16'($urandom);
            endcase
            send(st_tbl[$urandom_range(0, 5)], 8'($urandom), qpn_sel, 24'($urandom));
            if (i > 0) check("b2b.done", 64'(pdu_if.pdu_parse_done), 64'd1);
        end
        idle_hold("b2b");

        check("sb.empty", 64'(sb_q.size()), 64'd0);
        check("sb.pulses", 64'(n_seen), 64'(n_sent));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
